// File: rtl/dma_pkg.sv
// Shared types and constants for the transmit-side DMA stream source.
package dma_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} dma_src_state_t;
  localparam int unsigned DMA_WORD_BYTES = 4;
endpackage

// File: rtl/dma_rd_fifo.sv
// Read-response FIFO; head is driven from storage registers, so a push is visible the next cycle.
// Push and pop in the same cycle are accepted even when full; pop on empty is ignored.
module dma_rd_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_dat_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic [DATA_W-1:0]             head_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dma_stream_source.sv
// DMA source: reads i_len words from memory and streams them out; first word 3 cycles after start at 1-cycle memory latency.
// Requests are only issued when the response FIFO has room for their data, so downstream stalls throttle memory reads.
module dma_stream_source
  import dma_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  input  logic              i_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  dma_src_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d, popped_q, popped_d, len_last;
  logic [CW-1:0]     outst_q, outst_d, fifo_cnt;
  logic [SW-1:0]     credit_use;
  logic              fifo_full, fifo_empty, pop, push, gnt_acc, credit_ok;

  assign pop      = o_valid && i_ready;
  assign push     = i_mem_rvalid && (outst_q != '0) && (!fifo_full || pop);
  assign gnt_acc  = o_mem_req && i_mem_gnt;
  assign len_last = len_q - LEN_W'(1);

  // A word being popped this cycle frees its slot in time for a new request.
  assign credit_use = SW'(outst_q) + SW'(fifo_cnt) - SW'(pop);
  assign credit_ok  = credit_use < SW'(FIFO_DEPTH);

  dma_rd_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (i_mem_rdata),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt),
    .head_o     (o_data)
  );

  assign o_valid    = !fifo_empty;
  assign o_last     = o_valid && (popped_q == len_last);
  assign o_mem_addr = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = (i_len == '0) ? DONE : ISSUE;
      ISSUE:   if (gnt_acc && issued_q == len_last) state_d = DRAIN;
      DRAIN:   if (pop && popped_q == len_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state_q != IDLE);
    o_done    = (state_q == DONE);
    o_mem_req = (state_q == ISSUE) && credit_ok;
  end

  always_comb begin
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q;
    outst_d  = outst_q + CW'(gnt_acc) - CW'(push);
    if (state_q == IDLE && i_start) begin
      addr_d   = i_src_addr & ~ADDR_W'(DMA_WORD_BYTES - 1);
      len_d    = i_len;
      issued_d = '0;
      popped_d = '0;
      outst_d  = '0;
    end else begin
      if (gnt_acc) begin
        issued_d = issued_q + LEN_W'(1);
        addr_d   = addr_q + ADDR_W'(DMA_WORD_BYTES);
      end
      if (pop) popped_d = popped_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      outst_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      outst_q  <= outst_d;
    end
  end
endmodule
